// File: rtl/pwm_multi_ch.sv
// Multi-channel PWM with byte-wide register bank and period-boundary shadow reload.
// Optional sticky period-end interrupt enabled by defining PWM_IRQ_EN.
module pwm_multi_ch #(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned ADDR_W = 5,
  parameter logic [7:0]  ID_VAL = 8'h97
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] addr,
  input  logic [7:0]        wr_data,
  output logic [7:0]        rd_data,
  input  logic [NUM_CH-1:0] start_ext,
  output logic [NUM_CH-1:0] pwm,
  output logic [NUM_CH-1:0] period_end,
  output logic              irq
);

  localparam logic [15:0] HighRst = 16'h8214;
  localparam logic [15:0] FreqRst = 16'hC350;

  typedef enum logic {StIdle, StRun} state_e;

  logic [NUM_CH-1:0] ctrl_q;
  logic [NUM_CH-1:0] en;
  logic [NUM_CH-1:0] wrap;
  logic [NUM_CH-1:0] status_rd;
  logic [NUM_CH-1:0] mask_rd;
  logic [NUM_CH-1:0] pwm_q;
  logic [NUM_CH-1:0] pe_q;
  logic [15:0]       high_q    [NUM_CH];
  logic [15:0]       freq_q    [NUM_CH];
  logic [15:0]       high_sh_q [NUM_CH];
  logic [15:0]       freq_sh_q [NUM_CH];
  logic [15:0]       cnt_q     [NUM_CH];
  state_e            state_q   [NUM_CH];

  logic              ctrl_we;
  logic [NUM_CH-1:0] hl_we, hm_we, fl_we, fm_we;
  logic [ADDR_W-3:0] word;

  // Channel c occupies the 4-byte word at index c+1.
  assign word = addr[ADDR_W-1:2];

  always_comb begin
    ctrl_we = wr_en && (addr == ADDR_W'(1));
    hl_we   = '0;
    hm_we   = '0;
    fl_we   = '0;
    fm_we   = '0;
    for (int c = 0; c < int'(NUM_CH); c++) begin
      if (wr_en && (word == (ADDR_W-2)'(c + 1))) begin
        unique case (addr[1:0])
          2'd0:    hl_we[c] = 1'b1;
          2'd1:    hm_we[c] = 1'b1;
          2'd2:    fl_we[c] = 1'b1;
          default: fm_we[c] = 1'b1;
        endcase
      end
    end
  end

  assign en = ctrl_q | start_ext;

  always_comb begin
    wrap = '0;
    for (int c = 0; c < int'(NUM_CH); c++) begin
      wrap[c] = (state_q[c] == StRun) && en[c] && (freq_sh_q[c] != 16'd0) &&
                (cnt_q[c] == freq_sh_q[c] - 16'd1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_q <= '0;
      for (int c = 0; c < int'(NUM_CH); c++) begin
        high_q[c] <= HighRst;
        freq_q[c] <= FreqRst;
      end
    end else begin
      if (ctrl_we) ctrl_q <= wr_data[NUM_CH-1:0];
      for (int c = 0; c < int'(NUM_CH); c++) begin
        if (hl_we[c]) high_q[c][7:0]  <= wr_data;
        if (hm_we[c]) high_q[c][15:8] <= wr_data;
        if (fl_we[c]) freq_q[c][7:0]  <= wr_data;
        if (fm_we[c]) freq_q[c][15:8] <= wr_data;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_q <= '0;
      pe_q  <= '0;
      for (int c = 0; c < int'(NUM_CH); c++) begin
        state_q[c]   <= StIdle;
        cnt_q[c]     <= 16'd0;
        high_sh_q[c] <= HighRst;
        freq_sh_q[c] <= FreqRst;
      end
    end else begin
      for (int c = 0; c < int'(NUM_CH); c++) begin
        if (state_q[c] == StIdle) begin
          cnt_q[c] <= 16'd0;
          pwm_q[c] <= 1'b0;
          pe_q[c]  <= 1'b0;
          if (en[c]) begin
            high_sh_q[c] <= high_q[c];
            freq_sh_q[c] <= freq_q[c];
            state_q[c]   <= StRun;
          end
        end else if (!en[c]) begin
          // Abort immediately; the current period is not finished.
          state_q[c] <= StIdle;
          cnt_q[c]   <= 16'd0;
          pwm_q[c]   <= 1'b0;
          pe_q[c]    <= 1'b0;
        end else if (freq_sh_q[c] == 16'd0) begin
          cnt_q[c] <= 16'd0;
          pwm_q[c] <= 1'b0;
          pe_q[c]  <= 1'b0;
        end else begin
          pwm_q[c] <= (cnt_q[c] < high_sh_q[c]);
          pe_q[c]  <= wrap[c];
          if (wrap[c]) begin
            cnt_q[c]     <= 16'd0;
            high_sh_q[c] <= high_q[c];
            freq_sh_q[c] <= freq_q[c];
          end else begin
            cnt_q[c] <= cnt_q[c] + 16'd1;
          end
        end
      end
    end
  end

  assign pwm        = pwm_q;
  assign period_end = pe_q;

`ifdef PWM_IRQ_EN
  logic [NUM_CH-1:0] status_q;
  logic [NUM_CH-1:0] mask_q;
  logic              irq_q;
  logic              status_we;
  logic              mask_we;

  assign status_we = wr_en && (addr == ADDR_W'(2));
  assign mask_we   = wr_en && (addr == ADDR_W'(3));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      status_q <= '0;
      mask_q   <= '0;
      irq_q    <= 1'b0;
    end else begin
      // Write-1-to-clear, with a same-cycle set taking priority.
      status_q <= (status_q & ~(status_we ? wr_data[NUM_CH-1:0] : {NUM_CH{1'b0}})) | wrap;
      if (mask_we) mask_q <= wr_data[NUM_CH-1:0];
      irq_q <= |(status_q & mask_q);
    end
  end

  assign status_rd = status_q;
  assign mask_rd   = mask_q;
  assign irq       = irq_q;
`else
  assign status_rd = '0;
  assign mask_rd   = '0;
  assign irq       = 1'b0;
`endif

  always_comb begin
    rd_data = 8'h00;
    if (addr == ADDR_W'(0))      rd_data = ID_VAL;
    else if (addr == ADDR_W'(1)) rd_data = 8'(ctrl_q);
    else if (addr == ADDR_W'(2)) rd_data = 8'(status_rd);
    else if (addr == ADDR_W'(3)) rd_data = 8'(mask_rd);
    for (int c = 0; c < int'(NUM_CH); c++) begin
      if (word == (ADDR_W-2)'(c + 1)) begin
        unique case (addr[1:0])
          2'd0:    rd_data = high_q[c][7:0];
          2'd1:    rd_data = high_q[c][15:8];
          2'd2:    rd_data = freq_q[c][7:0];
          default: rd_data = freq_q[c][15:8];
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pwm_multi_ch.sv
// Randomized self-checking bench for pwm_multi_ch against a waveform-queue reference model.
module tb_pwm_multi_ch;

  localparam int NCH = 4;
  localparam int AW  = 5;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           wr_en = 1'b0;
  logic [AW-1:0]  addr = '0;
  logic [7:0]     wr_data = '0;
  logic [7:0]     rd_data;
  logic [NCH-1:0] start_ext = '0;
  logic [NCH-1:0] pwm;
  logic [NCH-1:0] period_end;
  logic           irq;

  pwm_multi_ch #(.NUM_CH(NCH), .ADDR_W(AW), .ID_VAL(8'h97)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_en      (wr_en),
    .addr       (addr),
    .wr_data    (wr_data),
    .rd_data    (rd_data),
    .start_ext  (start_ext),
    .pwm        (pwm),
    .period_end (period_end),
    .irq        (irq)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: bank contents plus, per running channel, the remaining
  // expected pwm samples of the current period.
  int             m_high [NCH];
  int             m_freq [NCH];
  int             m_hsh  [NCH];
  int             m_fsh  [NCH];
  bit             m_run  [NCH];
  bit             pq     [NCH][$];
  logic [NCH-1:0] m_ctrl, m_status, m_mask, m_pwm, m_pe;
  logic           m_irq;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  function automatic void fill_period(int c);
    pq[c].delete();
    for (int i = 0; i < m_fsh[c]; i++) pq[c].push_back(i < m_hsh[c]);
  endfunction

  function automatic void model_reset();
    for (int c = 0; c < NCH; c++) begin
      m_high[c] = 'h8214;
      m_freq[c] = 'hC350;
      m_run[c]  = 1'b0;
      pq[c].delete();
    end
    m_ctrl = '0; m_status = '0; m_mask = '0; m_pwm = '0; m_pe = '0; m_irq = 1'b0;
  endfunction

  function automatic logic [7:0] model_read(int a);
    int c, k;
    if (a == 0) return 8'h97;
    if (a == 1) return 8'(m_ctrl);
`ifdef PWM_IRQ_EN
    if (a == 2) return 8'(m_status);
    if (a == 3) return 8'(m_mask);
`endif
    if (a >= 4 && a < 4 + 4 * NCH) begin
      c = (a - 4) / 4;
      k = (a - 4) % 4;
      case (k)
        0:       return 8'(m_high[c] % 256);
        1:       return 8'(m_high[c] / 256);
        2:       return 8'(m_freq[c] % 256);
        default: return 8'(m_freq[c] / 256);
      endcase
    end
    return 8'h00;
  endfunction

  function automatic void model_write(int a, int d);
    int c, k;
    if (a == 1) m_ctrl = d[NCH-1:0];
`ifdef PWM_IRQ_EN
    if (a == 2) m_status = m_status & ~d[NCH-1:0];
    if (a == 3) m_mask = d[NCH-1:0];
`endif
    if (a >= 4 && a < 4 + 4 * NCH) begin
      c = (a - 4) / 4;
      k = (a - 4) % 4;
      case (k)
        0:       m_high[c] = (m_high[c] / 256) * 256 + d;
        1:       m_high[c] = d * 256 + m_high[c] % 256;
        2:       m_freq[c] = (m_freq[c] / 256) * 256 + d;
        default: m_freq[c] = d * 256 + m_freq[c] % 256;
      endcase
    end
  endfunction

  // Advance the model by one clock edge using the inputs currently driven.
  function automatic void model_step();
    logic [NCH-1:0] en, npwm, npe;
    logic           nirq;
    en   = m_ctrl | start_ext;
    npwm = '0;
    npe  = '0;
    nirq = |(m_status & m_mask);
    for (int c = 0; c < NCH; c++) begin
      if (!m_run[c]) begin
        if (en[c]) begin
          m_run[c] = 1'b1;
          m_hsh[c] = m_high[c];
          m_fsh[c] = m_freq[c];
          fill_period(c);
        end
      end else if (!en[c]) begin
        m_run[c] = 1'b0;
        pq[c].delete();
      end else if (m_fsh[c] != 0) begin
        npwm[c] = pq[c].pop_front();
        npe[c]  = (pq[c].size() == 0);
        if (npe[c]) begin
          m_hsh[c] = m_high[c];
          m_fsh[c] = m_freq[c];
          fill_period(c);
        end
      end
    end
    if (wr_en) model_write(int'(addr), int'(wr_data));
`ifdef PWM_IRQ_EN
    m_status = m_status | npe;
    m_irq    = nirq;
`else
    m_irq = 1'b0;
`endif
    m_pwm = npwm;
    m_pe  = npe;
  endfunction

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check("pwm", 32'(pwm), 32'(m_pwm));
    check("period_end", 32'(period_end), 32'(m_pe));
    check("irq", 32'(irq), 32'(m_irq));
  endtask

  task automatic wr(input int a, input int d);
    addr    = AW'(a);
    wr_data = 8'(d);
    wr_en   = 1'b1;
    tick();
    wr_en   = 1'b0;
  endtask

  task automatic rd_check(input int a);
    addr = AW'(a);
    #1;
    check($sformatf("rd_%0d", a), 32'(rd_data), 32'(model_read(a)));
  endtask

  task automatic mid_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    check("rst_pwm", 32'(pwm), 32'(m_pwm));
    check("rst_pe", 32'(period_end), 32'(m_pe));
    check("rst_irq", 32'(irq), 32'(m_irq));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    int ra, wa, wd, k;
    logic [7:0] exp_rst [8];
    exp_rst = '{8'h97, 8'h00, 8'h00, 8'h00, 8'h14, 8'h82, 8'h50, 8'hC3};
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Reset values of the register bank
    for (int a = 0; a < 8; a++) begin
      addr = AW'(a);
      #1;
      check($sformatf("reset_rd_%0d", a), 32'(rd_data), 32'(exp_rst[a]));
    end
    tick();

    // Channel 0: 3 high / 7 low
    wr(4, 3); wr(5, 0); wr(6, 10); wr(7, 0);
    wr(1, 1);
    repeat (25) tick();

    // Mid-period HIGH change applies only from the next period
    for (int i = 0; i < 20 && pq[0].size() != 5; i++) tick();
    wr(4, 7);
    repeat (25) tick();

    // Channel 1: FREQ=0 holds low with no period_end, then HIGH>=FREQ holds high
    wr(10, 0); wr(11, 0);
    start_ext = 4'b0010;
    repeat (15) tick();
    wr(8, 12); wr(9, 0); wr(10, 10);
    start_ext = 4'b0000;
    tick();
    start_ext = 4'b0010;
    repeat (20) tick();

    // Clear CTRL mid-period, then reset while channel 1 is driving high
    for (int i = 0; i < 20 && pq[0].size() != 8; i++) tick();
    wr(1, 0);
    repeat (3) tick();
    check("ch1_high_before_reset", 32'(pwm[1]), 32'd1);
    mid_reset();
    start_ext = '0;
    for (int a = 0; a < 32; a++) rd_check(a);
    tick();

    // Status/mask writes
    wr(2, 8'hFF); wr(3, 8'hFF); wr(0, 8'h12); wr(25, 8'h55);
    for (int a = 0; a < 4; a++) rd_check(a);
    wr(3, 0);

`ifdef PWM_IRQ_EN
    wr(3, 1); wr(6, 4); wr(7, 0); wr(4, 1); wr(5, 0); wr(1, 1);
    repeat (12) tick();
    rd_check(2);
    for (int i = 0; i < 20 && pq[0].size() != 1; i++) tick();
    wr(2, 1);
    addr = AW'(2);
    #1;
    check("status_set_wins", 32'(rd_data[0]), 32'd1);
    wr(2, 1);
    repeat (4) tick();
`endif

    // Small periods on all channels before random traffic
    wr(1, 0);
    for (int c = 0; c < NCH; c++) begin
      wr(4 + 4 * c, 2 + c); wr(5 + 4 * c, 0);
      wr(6 + 4 * c, 5 + c); wr(7 + 4 * c, 0);
    end

    for (int i = 0; i < 1500; i++) begin
      ra = int'($urandom_range(0, 31));
      rd_check(ra);
      if ($urandom_range(0, 3) == 0) begin
        wa = int'($urandom_range(0, 31));
        if (wa >= 4 && wa < 4 + 4 * NCH) begin
          k  = (wa - 4) % 4;
          wd = (k % 2 == 1) ? (($urandom_range(0, 9) == 0) ? 1 : 0)
                            : int'($urandom_range(0, 24));
        end else begin
          wd = int'($urandom_range(0, 255));
        end
        addr    = AW'(wa);
        wr_data = 8'(wd);
        wr_en   = 1'b1;
      end
      if ($urandom_range(0, 15) == 0) start_ext = NCH'($urandom);
      tick();
      wr_en = 1'b0;
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
